// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding and
// the credit counter width helper.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   // Bits needed to hold 0..length free slots.
   function automatic int unsigned credit_w(input int unsigned length);
      return $clog2(length + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: grants the first set request after
// 'last' in circular order; 'last' itself has the lowest priority.
module rr_pick #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [NREQ-1:0]         gnt,
   output logic                    valid
);

   localparam int unsigned IDW = $clog2(NREQ);

   int unsigned    idx;
   logic [IDW-1:0] idx_w;

   // Scan offsets 1..NREQ from the last grant, take the first hit.
   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = 0;
      idx_w = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = 32'(last) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_w = IDW'(idx);
         if (!valid && req[idx_w]) begin
            gnt[idx_w] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters,
// with an internal credit counter tracking FIFO free space.
// Optional burst locking is enabled by defining FIFO_WR_ARB_LOCK_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N      = 8,
   parameter int unsigned NREQ   = 4,
   parameter int unsigned LENGTH = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*N-1:0]             data,
`ifdef FIFO_WR_ARB_LOCK_EN
   input  logic [NREQ-1:0]               lock,
`endif
   output logic [NREQ-1:0]               ack,
   input  logic                          fifo_pop,
   output logic                          fifo_we,
   output logic [N-1:0]                  fifo_a,
   output logic [$clog2(NREQ)-1:0]       grant_id,
   output logic [credit_w(LENGTH)-1:0]   credits,
   output logic                          err
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = credit_w(LENGTH);

   state_t          state, state_next;
   logic [NREQ-1:0] elig, rr_gnt, ack_next;
   logic            rr_valid, pick_valid, pop_valid, have_credit, grant_ok;
   logic [IDW-1:0]  pick_idx, grant_next;
   logic [N-1:0]    a_next;
   logic [CW-1:0]   credits_next;
   logic            err_next;

   // A pop in the decision cycle frees a slot for that same decision.
   assign pop_valid   = fifo_pop && (credits != CW'(LENGTH));
   assign have_credit = (credits != '0) || pop_valid;

   // The requester being acked this cycle has not yet advanced its req.
   assign elig = req & ~ack;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (elig),
      .last  (grant_id),
      .gnt   (rr_gnt),
      .valid (rr_valid)
   );

   // Winner index: round-robin result, or the current owner while locked.
   always_comb begin
      pick_idx   = grant_id;
      pick_valid = rr_valid;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (rr_gnt[i]) pick_idx = IDW'(i);
      end
`ifdef FIFO_WR_ARB_LOCK_EN
      // Locked owner bypasses the ack mask so a burst runs every cycle.
      if (lock[grant_id] && req[grant_id]) begin
         pick_idx   = grant_id;
         pick_valid = 1'b1;
      end
`endif
   end

   // Next-state, registered outputs and credit accounting.
   always_comb begin
      state_next = ST_IDLE;
      ack_next   = '0;
      grant_next = grant_id;
      a_next     = fifo_a;
      grant_ok   = 1'b0;
      if (pick_valid) begin
         if (have_credit) begin
            grant_ok           = 1'b1;
            state_next         = ST_ISSUE;
            ack_next[pick_idx] = 1'b1;
            grant_next         = pick_idx;
            for (int unsigned i = 0; i < NREQ; i++) begin
               if (IDW'(i) == pick_idx) a_next = data[i*N +: N];
            end
         end else begin
            state_next = ST_STALL;
         end
      end
      // Credit is consumed at grant time so the counter can never underflow.
      credits_next = credits - CW'(grant_ok) + CW'(pop_valid);
      err_next     = err | (fifo_pop && !pop_valid);
   end

   // State and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= ST_IDLE;
         ack      <= '0;
         grant_id <= IDW'(NREQ - 1);
         fifo_a   <= '0;
         credits  <= CW'(LENGTH);
         err      <= 1'b0;
      end else begin
         state    <= state_next;
         ack      <= ack_next;
         grant_id <= grant_next;
         fifo_a   <= a_next;
         credits  <= credits_next;
         err      <= err_next;
      end
   end

   assign fifo_we = (state == ST_ISSUE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (N=8, NREQ=4, LENGTH=4).
module tb_fifo_wr_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  lock;
   logic [3:0]  ack;
   logic        fifo_pop;
   logic        fifo_we;
   logic [7:0]  fifo_a;
   logic [1:0]  grant_id;
   logic [2:0]  credits;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] req;
      logic       pop;
      logic [3:0] lock;
      logic       we;
      logic [7:0] a;
      logic [3:0] ack;
      logic [1:0] gid;
      logic [2:0] cr;
      logic       err;
   } vec_t;

   vec_t main_v[$];
   vec_t lock_v[$];

   always #5 CLK = ~CLK;

   fifo_wr_arbiter #(.N(8), .NREQ(4), .LENGTH(4)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .req      (req),
      .data     (data),
`ifdef FIFO_WR_ARB_LOCK_EN
      .lock     (lock),
`endif
      .ack      (ack),
      .fifo_pop (fifo_pop),
      .fifo_we  (fifo_we),
      .fifo_a   (fifo_a),
      .grant_id (grant_id),
      .credits  (credits),
      .err      (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t e);
      chk({tag, " fifo_we"},  32'(fifo_we),  32'(e.we));
      chk({tag, " ack"},      32'(ack),      32'(e.ack));
      chk({tag, " grant_id"}, 32'(grant_id), 32'(e.gid));
      chk({tag, " credits"},  32'(credits),  32'(e.cr));
      chk({tag, " err"},      32'(err),      32'(e.err));
      if (e.we) chk({tag, " fifo_a"}, 32'(fifo_a), 32'(e.a));
   endtask

   task automatic run_vec(input string tag, input vec_t e);
      req      = e.req;
      fifo_pop = e.pop;
      lock     = e.lock;
      @(posedge CLK);
      #1;
      chk_all(tag, e);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r;
      // req pop lock | we a ack gid cr err
      main_v.push_back('{4'b1111, 1'b0, 4'b0, 1'b1, 8'hAA, 4'b0001, 2'd0, 3'd3, 1'b0});
      main_v.push_back('{4'b1111, 1'b0, 4'b0, 1'b1, 8'hBB, 4'b0010, 2'd1, 3'd2, 1'b0});
      main_v.push_back('{4'b1111, 1'b0, 4'b0, 1'b1, 8'hCC, 4'b0100, 2'd2, 3'd1, 1'b0});
      main_v.push_back('{4'b1111, 1'b0, 4'b0, 1'b1, 8'hDD, 4'b1000, 2'd3, 3'd0, 1'b0});
      main_v.push_back('{4'b1111, 1'b0, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd3, 3'd0, 1'b0});
      main_v.push_back('{4'b1111, 1'b0, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd3, 3'd0, 1'b0});
      main_v.push_back('{4'b0001, 1'b1, 4'b0, 1'b1, 8'hAA, 4'b0001, 2'd0, 3'd0, 1'b0});
      main_v.push_back('{4'b0010, 1'b1, 4'b0, 1'b1, 8'hBB, 4'b0010, 2'd1, 3'd0, 1'b0});
      main_v.push_back('{4'b0000, 1'b1, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 3'd1, 1'b0});
      main_v.push_back('{4'b0000, 1'b1, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 3'd2, 1'b0});
      main_v.push_back('{4'b0000, 1'b1, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 3'd3, 1'b0});
      main_v.push_back('{4'b0000, 1'b1, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 3'd4, 1'b0});
      main_v.push_back('{4'b0000, 1'b1, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 3'd4, 1'b1});
      main_v.push_back('{4'b0000, 1'b0, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 3'd4, 1'b1});
      main_v.push_back('{4'b0100, 1'b0, 4'b0, 1'b1, 8'hCC, 4'b0100, 2'd2, 3'd3, 1'b1});
      main_v.push_back('{4'b0100, 1'b0, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd2, 3'd3, 1'b1});
      main_v.push_back('{4'b0100, 1'b0, 4'b0, 1'b1, 8'hCC, 4'b0100, 2'd2, 3'd2, 1'b1});
      main_v.push_back('{4'b0000, 1'b0, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd2, 3'd2, 1'b1});
      main_v.push_back('{4'b1000, 1'b1, 4'b0, 1'b1, 8'hDD, 4'b1000, 2'd3, 3'd2, 1'b1});
      main_v.push_back('{4'b0000, 1'b0, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd3, 3'd2, 1'b1});

      lock_v.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hCC, 4'b0100, 2'd2, 3'd3, 1'b0});
      lock_v.push_back('{4'b0110, 1'b0, 4'b0100, 1'b1, 8'hCC, 4'b0100, 2'd2, 3'd2, 1'b0});
      lock_v.push_back('{4'b0110, 1'b0, 4'b0100, 1'b1, 8'hCC, 4'b0100, 2'd2, 3'd1, 1'b0});
      lock_v.push_back('{4'b1110, 1'b0, 4'b0000, 1'b1, 8'hDD, 4'b1000, 2'd3, 3'd0, 1'b0});
      lock_v.push_back('{4'b0110, 1'b1, 4'b0000, 1'b1, 8'hBB, 4'b0010, 2'd1, 3'd0, 1'b0});
      lock_v.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd1, 3'd0, 1'b0});

      RST      = 1'b1;
      req      = '0;
      lock     = '0;
      fifo_pop = 1'b0;
      data     = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      r = '{4'b0, 1'b0, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd3, 3'd4, 1'b0};
      chk_all("reset", r);
      chk("reset fifo_a", 32'(fifo_a), 32'h0);

      foreach (main_v[i]) run_vec($sformatf("main[%0d]", i), main_v[i]);

      // Asynchronous reset with a request pending: no clock edge needed,
      // and the pending word is dropped without an ack.
      req = 4'b0001;
      #2;
      RST = 1'b1;
      #1;
      r = '{4'b0, 1'b0, 4'b0, 1'b0, 8'h00, 4'b0000, 2'd3, 3'd4, 1'b0};
      chk_all("async_rst", r);
      chk("async_rst fifo_a", 32'(fifo_a), 32'h0);
      @(posedge CLK);
      #1;
      chk("rst_hold ack", 32'(ack), 32'h0);
      chk("rst_hold fifo_we", 32'(fifo_we), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      r = '{4'b0001, 1'b0, 4'b0, 1'b1, 8'hAA, 4'b0001, 2'd0, 3'd3, 1'b0};
      run_vec("represent", r);
      req = '0;

`ifdef FIFO_WR_ARB_LOCK_EN
      do_reset();
      foreach (lock_v[i]) run_vec($sformatf("lock[%0d]", i), lock_v[i]);
`endif

      req      = '0;
      fifo_pop = 1'b0;
      repeat (2) @(posedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
